wrr_grant_scheduler: RTL
========================

Name: wrr_grant_scheduler

Overview:
- Weighted round-robin scheduler that shares one burst-capable downstream resource among NumReq requesters.
- Selects an owner, holds the grant for up to a per-requester weight of beats, then rotates priority to the next requester.
- Sits between the requester interfaces and the shared resource, and complements the existing single-cycle arbiter where multi-beat ownership is needed.

Parameters:
- NumReq, 3, number of requesters.
- WW, 4, width of each weight field.
- IdW, 2, width of the owner index (must satisfy 2^IdW >= NumReq).

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  reset; asynchronous, active-low.
- req_in  in  NumReq  per-requester request level; held high while the requester wants the resource.
- last_in  in  NumReq  per-requester end-of-burst flag; only meaningful together with beat_done.
- weight_in  in  NumReq*WW  weight of requester i in bits [i*WW +: WW]; max beats per grant.
- beat_done  in  1  resource accepted one beat from the current owner this cycle.
- grant_out  out  NumReq  one-hot grant, registered.
- grant_valid  out  1  OR of grant_out, registered.
- grant_id  out  IdW  index of the current owner; 0 when idle.
- beat_cnt  out  WW  beats completed in the current grant.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low; clock port clk, reset port rstN.
- Reset values: all outputs 0, state IDLE, rotation pointer ptr = 0, latched weight wlim = 0.
- States:
  - IDLE: no owner.
  - GRANT: exactly one grant_out bit high.
- IDLE -> GRANT:
  - Condition: req_in != 0.
  - Winner: first set bit of req_in searching ptr, ptr+1, ... mod NumReq.
  - Grant appears on the cycle after the request is seen (1-cycle latency).
  - beat_cnt <= 0.
  - wlim <= the winner's weight; weight 0 is treated as 1.
- In GRANT:
  - beat_done with no termination: beat_cnt increments.
  - beat_done with grant_valid = 0: ignored.
- Termination condition (evaluated each cycle), any one of:
  - req_in[grant_id] == 0 (drop), regardless of beat_done; or
  - beat_done && last_in[grant_id]; or
  - beat_done && beat_cnt == wlim-1.
- On termination:
  - ptr <= grant_id+1, wrapping NumReq-1 -> 0.
  - Re-arbitrate in the same cycle from the new ptr over req_in with the old owner's bit masked.
  - If another requester wins, its grant is registered next cycle (back-to-back, no idle gap), with beat_cnt <= 0 and wlim reloaded.
  - If no other requester wins: go to IDLE, clear grant_out, grant_valid and grant_id.
- Old owner still requesting with no other requester:
  - The scheduler passes through IDLE for exactly one cycle.
  - It then re-grants the old owner under the normal IDLE rule.
- Weight sampling: weight_in is sampled only when a grant is issued; changes mid-grant have no effect until the next grant.
- last_in of non-owners is ignored.
- Invariants:
  - grant_out is always one-hot or zero.
  - grant_id always equals the set bit index.
  - beat_cnt never reaches wlim while granted.
- Reset mid-grant: outputs clear asynchronously on rstN fall; ptr returns to 0.

Test Plan:
1. Reset:
   - Stimulus: assert rstN=0 at t=0, release at 30 ns; req_in=000.
   - Response: grant_out=000, grant_valid=0, grant_id=0, beat_cnt=0 throughout.
2. Single requester with weight limit:
   - Stimulus: req_in=001, weight0=3, beat_done high every cycle, last_in=0.
   - Response: grant_out=001 one cycle after the request; beat_cnt goes 0,1,2; grant ends after the 3rd beat; one IDLE cycle; re-grant 001.
3. Three-way rotation:
   - Stimulus: req_in=111, all weights=2, beat_done continuous.
   - Response: grant sequence 001,001,010,010,100,100,001..., with no idle cycles between owners.
4. Early termination by last_in:
   - Stimulus: req_in=110, weight1=4, last_in[1] pulsed with the 2nd beat.
   - Response: owner 1 released after 2 beats; grant_out=100 on the next cycle; beat_cnt reset to 0.
5. Drop and zero weight:
   - Stimulus: owner 2 drops req_in mid-grant with req_in[0]=1; separately, weight0=0.
   - Response: drop gives grant_out=001 on the next cycle with ptr=0; requester 0 with weight 0 receives exactly 1 beat per grant.
6. Asynchronous reset mid-burst:
   - Stimulus: req_in=011, rstN pulsed low during owner 1's grant between clock edges.
   - Response: outputs are 0 immediately; after release, first grant is 001 (ptr=0).

Source files
------------

// File: rtl/wrr_grant_scheduler.sv
// ============================================================================
// Module   : wrr_grant_scheduler
// Purpose  : Weighted round-robin scheduler granting multi-beat ownership of a
//            shared downstream resource to one of NUM_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrr_grant_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int WW      = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [NUM_REQ-1:0]    req_in,
    input  logic [NUM_REQ-1:0]    last_in,
    input  logic [NUM_REQ*WW-1:0] weight_in,
    input  logic                  beat_done,
    output logic [NUM_REQ-1:0]    grant_out,
    output logic                  grant_valid,
    output logic [ID_W-1:0]       grant_id,
    output logic [WW-1:0]         beat_cnt
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [ID_W-1:0]      r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]      r_grant_id, w_grant_id_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic                 r_grant_valid;
    logic [WW-1:0]        r_beat_cnt, w_beat_cnt_nxt;
    logic [WW-1:0]        r_wlim, w_wlim_nxt;

    logic [WW-1:0]        w_weight [NUM_REQ];
    logic [ID_W-1:0]      w_ptr_rot;
    logic [ID_W-1:0]      w_arb_start;
    logic [NUM_REQ-1:0]   w_arb_req;
    logic                 w_arb_found;
    logic [ID_W-1:0]      w_arb_idx;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [WW-1:0]        w_win_weight;
    logic [WW-1:0]        w_win_wlim;
    logic                 w_term;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_weight
            assign w_weight[gi] = weight_in[gi*WW +: WW];
        end
    endgenerate

    assign w_ptr_rot = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    // While granted, the search starts after the owner and excludes it, so a
    // lone persistent requester falls back to IDLE for one cycle.
    assign w_arb_start = (r_state == S_GRANT) ? w_ptr_rot : r_ptr;
    assign w_arb_req   = (r_state == S_GRANT) ? (req_in & ~r_grant) : req_in;

    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = int'(w_arb_start) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_arb_found && w_arb_req[ID_W'(j)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = ID_W'(j);
            end
        end
    end

    assign w_win_oh     = NUM_REQ'(1) << w_arb_idx;
    assign w_win_weight = w_weight[w_arb_idx];
    assign w_win_wlim   = (w_win_weight == '0) ? WW'(1) : w_win_weight;

    assign w_term = (r_state == S_GRANT) &&
                    (!req_in[r_grant_id] ||
                     (beat_done && (last_in[r_grant_id] || (r_beat_cnt == r_wlim - WW'(1)))));

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        w_wlim_nxt     = r_wlim;
        case (r_state)
            S_IDLE: begin
                if (w_arb_found) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_nxt    = w_win_oh;
                    w_grant_id_nxt = w_arb_idx;
                    w_beat_cnt_nxt = '0;
                    w_wlim_nxt     = w_win_wlim;
                end
            end
            S_GRANT: begin
                if (w_term) begin
                    w_ptr_nxt      = w_ptr_rot;
                    w_beat_cnt_nxt = '0;
                    if (w_arb_found) begin
                        w_grant_nxt    = w_win_oh;
                        w_grant_id_nxt = w_arb_idx;
                        w_wlim_nxt     = w_win_wlim;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_grant_nxt    = '0;
                        w_grant_id_nxt = '0;
                    end
                end else if (beat_done) begin
                    w_beat_cnt_nxt = r_beat_cnt + WW'(1);
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_beat_cnt    <= '0;
            r_wlim        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= |w_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_wlim        <= w_wlim_nxt;
        end
    end

    assign grant_out   = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign beat_cnt    = r_beat_cnt;

endmodule

`default_nettype wire
